// File: rtl/core_inst_sequencer.sv
// Generates the 34-bit instruction stream that drives `core` through one convolution layer:
// per kernel position: weight fetch, PE load, gap, activation fetch, execute, PSUM drain.
module core_inst_sequencer #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_kij = 9,
    parameter int len_nij = 36,
    parameter int gap     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] w_base,
    input  logic [10:0] a_base,
    input  logic [10:0] p_base,
    input  logic        valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done
);

    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
    localparam int TW = 16;
    localparam int KW = (len_kij > 1) ? $clog2(len_kij) : 1;

    if (row < 1 || col < 1 || len_kij < 1 || len_nij < 1 || gap < 0) begin : g_param_check
        $error("core_inst_sequencer: invalid geometry parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLD,
        S_WPE,
        S_WGAP,
        S_ALD,
        S_EXE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state, state_n;
    logic [TW-1:0]  t, t_n;
    logic [KW-1:0]  kij, kij_n;
    logic [10:0]    w_q, a_q, p_q;
    logic [33:0]    inst_n;

    logic        acc, p_cen, p_wen, x_cen, x_wen;
    logic [10:0] p_addr, x_addr;
    logic        ofifo_rd, l0_rd, l0_wr, execute, load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            t     <= '0;
            kij   <= '0;
            w_q   <= '0;
            a_q   <= '0;
            p_q   <= '0;
            inst  <= IDLE_WORD;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            t     <= t_n;
            kij   <= kij_n;
            inst  <= inst_n;
            // Outputs are registered views of the state being left on this edge
            busy  <= (state != S_IDLE);
            done  <= (state == S_DONE);
            if (state == S_IDLE && start) begin
                w_q <= w_base;
                a_q <= a_base;
                p_q <= p_base;
            end
        end
    end

    always_comb begin
        state_n  = state;
        t_n      = t + 1'b1;
        kij_n    = kij;
        acc      = 1'b0;
        p_cen    = 1'b1;
        p_wen    = 1'b1;
        p_addr   = '0;
        x_cen    = 1'b1;
        x_wen    = 1'b1;
        x_addr   = '0;
        ofifo_rd = 1'b0;
        l0_rd    = 1'b0;
        l0_wr    = 1'b0;
        execute  = 1'b0;
        load     = 1'b0;

        unique case (state)
            S_IDLE: begin
                t_n   = '0;
                kij_n = '0;
                if (start) state_n = S_WLD;
            end
            S_WLD: begin
                // l0_wr trails the SRAM read by one cycle to cover its read latency
                if (t < TW'(col)) begin
                    x_cen  = 1'b0;
                    x_addr = w_q + 11'(kij * col) + t[10:0];
                end
                l0_wr = (t != '0);
                if (t == TW'(col)) begin
                    state_n = S_WPE;
                    t_n     = '0;
                end
            end
            S_WPE: begin
                l0_rd = 1'b1;
                load  = 1'b1;
                if (t == TW'(col - 1)) begin
                    state_n = (gap == 0) ? S_ALD : S_WGAP;
                    t_n     = '0;
                end
            end
            S_WGAP: begin
                if (t == TW'(gap - 1)) begin
                    state_n = S_ALD;
                    t_n     = '0;
                end
            end
            S_ALD: begin
                if (t < TW'(len_nij)) begin
                    x_cen  = 1'b0;
                    x_addr = a_q + t[10:0];
                end
                l0_wr = (t != '0);
                if (t == TW'(len_nij)) begin
                    state_n = S_EXE;
                    t_n     = '0;
                end
            end
            S_EXE: begin
                l0_rd   = 1'b1;
                execute = 1'b1;
                if (t == TW'(len_nij - 1)) begin
                    state_n = S_DRAIN;
                    t_n     = '0;
                end
            end
            S_DRAIN: begin
                t_n = t;
                if (valid && t < TW'(len_nij)) begin
                    ofifo_rd = 1'b1;
                    p_cen    = 1'b0;
                    p_wen    = 1'b0;
                    p_addr   = p_q + 11'(kij * len_nij) + t[10:0];
                    acc      = (kij != '0);
                    t_n      = t + 1'b1;
                    // Leave on the edge carrying the last write so DONE follows it directly
                    if (t == TW'(len_nij - 1)) begin
                        t_n = '0;
                        if (kij == KW'(len_kij - 1)) begin
                            state_n = S_DONE;
                        end else begin
                            kij_n   = kij + 1'b1;
                            state_n = S_WLD;
                        end
                    end
                end
            end
            S_DONE: begin
                t_n     = '0;
                state_n = S_IDLE;
            end
            default: begin
                t_n     = '0;
                state_n = S_IDLE;
            end
        endcase

        inst_n = {acc, p_cen, p_wen, p_addr, x_cen, x_wen, x_addr,
                  ofifo_rd, 2'b00, l0_rd, l0_wr, execute, load};
    end

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Scoreboard bench for core_inst_sequencer: expected xmem reads and PSUM writes are queued
// when a layer is started; a monitor pops and compares them as the DUT emits them.
module tb_core_inst_sequencer;

    localparam int COL     = 8;
    localparam int NIJ     = 36;
    localparam int KIJ     = 9;
    localparam int GAP     = 16;
    localparam int KIJ_LEN = (COL + 1) + COL + GAP + (NIJ + 1) + NIJ + NIJ;  // 142 with valid high
    localparam int EXE_K   = (COL + 1) + COL + GAP + (NIJ + 1);              // 70
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [10:0] w_base = '0;
    logic [10:0] a_base = '0;
    logic [10:0] p_base = '0;
    logic [33:0] inst;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    core_inst_sequencer #(
        .row(8), .col(COL), .len_kij(KIJ), .len_nij(NIJ), .gap(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .a_base(a_base), .p_base(p_base),
        .valid(valid), .inst(inst), .busy(busy), .done(done)
    );

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [10:0] exp_xrd[$];
    logic [11:0] exp_wr[$];   // {acc, psum addr}

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_layer(input logic [10:0] w, input logic [10:0] a, input logic [10:0] p);
        for (int k = 0; k < KIJ; k++) begin
            for (int t = 0; t < COL; t++) exp_xrd.push_back(w + 11'(k * COL + t));
            for (int t = 0; t < NIJ; t++) exp_xrd.push_back(a + 11'(t));
            for (int t = 0; t < NIJ; t++) exp_wr.push_back({(k != 0), p + 11'(k * NIJ + t)});
        end
    endtask

    // Monitor: compares every cycle of the instruction stream against the queues
    initial begin
        logic v_e, r_e, prev_xrd, prev_wr, prev_done;
        logic [11:0] ew;
        logic [10:0] ex;
        prev_xrd = 1'b0;
        prev_wr = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            v_e = valid;
            r_e = reset;
            #1;
            if (r_e) begin
                prev_xrd = 1'b0;
                prev_wr = 1'b0;
                prev_done = 1'b0;
            end else begin
                chk("ififo_bits", inst[5:4], 2'b00);
                chk("l0_wr_lag", inst[2], prev_xrd);
                if (inst[6]) chk("ofifo_rd_valid", v_e, 1'b1);
                if (!inst[32]) begin
                    wr_cnt++;
                    if (exp_wr.size() == 0) chk("extra_write_qsize", exp_wr.size(), 1);
                    else begin
                        ew = exp_wr.pop_front();
                        chk("psum_write", {inst[33], inst[31], inst[6], inst[30:20]},
                            {ew[11], 1'b0, 1'b1, ew[10:0]});
                    end
                end else if (inst[6]) begin
                    chk("ofifo_without_write", inst[6], 1'b0);
                end
                if (!inst[19]) begin
                    if (exp_xrd.size() == 0) chk("extra_xread_qsize", exp_xrd.size(), 1);
                    else begin
                        ex = exp_xrd.pop_front();
                        chk("xmem_read", {inst[18], inst[17:7]}, {1'b1, ex});
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("done_after_last_write", prev_wr, 1'b1);
                    chk("done_one_cycle", prev_done, 1'b0);
                end
                prev_xrd = !inst[19];
                prev_wr = !inst[32];
                prev_done = done;
            end
        end
    end

    // Runs one layer; done_k = cycle index of the done pulse, -1 on timeout, -2 on abort
    task automatic run_layer(input logic [10:0] w, input logic [10:0] a, input logic [10:0] p,
                             input bit stall, input int abort_k, input int max_k,
                             output int done_k);
        int wr0 = wr_cnt;
        int dn0 = done_cnt;
        push_layer(w, a, p);
        w_base = w;
        a_base = a;
        p_base = p;
        valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_k = -1;
        for (int k = 0; k < max_k; k++) begin
            tick();
            if (k == 0) begin
                chk("busy_rise", busy, 1'b1);
                chk("first_wld_word", {inst[19], inst[17:7]}, {1'b0, w});
            end
            if (k == COL + 1 || k == 2 * COL) chk("wpe_load", {inst[3], inst[0]}, 2'b11);
            if (k == 2 * COL + 1) chk("wpe_end", {inst[3], inst[0]}, 2'b00);
            if (k == EXE_K - 1) chk("exe_not_yet", inst[1], 1'b0);
            if (k == EXE_K) chk("exe_start", inst[1], 1'b1);
            if (k == abort_k + 1) begin
                chk("abort_inst", inst, IDLE_W);
                chk("abort_busy", busy, 1'b0);
                chk("abort_done", done, 1'b0);
                chk("abort_writes_done", wr_cnt - wr0, 3 * NIJ);
                chk("abort_wr_left", exp_wr.size(), (KIJ - 3) * NIJ);
                chk("abort_xrd_left", exp_xrd.size(), (KIJ - 4) * (COL + NIJ));
                exp_wr.delete();
                exp_xrd.delete();
                reset = 1'b0;
                done_k = -2;
                break;
            end
            // Busy-time start with different bases must not disturb the stream
            start = (k == 200);
            w_base = (k == 200) ? 11'd7 : w;
            a_base = (k == 200) ? 11'd7 : a;
            p_base = (k == 200) ? 11'd7 : p;
            if (k == abort_k) reset = 1'b1;
            valid = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (done) begin
                done_k = k;
                chk("busy_at_done", busy, 1'b1);
                break;
            end
        end
        start = 1'b0;
        if (done_k != -2) begin
            chk("layer_completed", (done_k >= 0), 1'b1);
            tick();
            chk("post_done_inst", inst, IDLE_W);
            chk("busy_fall", busy, 1'b0);
            chk("done_fall", done, 1'b0);
            chk("writes_per_layer", wr_cnt - wr0, KIJ * NIJ);
            chk("done_pulses", done_cnt - dn0, 1);
            chk("wr_queue_empty", exp_wr.size(), 0);
            chk("xrd_queue_empty", exp_xrd.size(), 0);
        end
    endtask

    initial begin
        int dk;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("reset_inst", inst, IDLE_W);
            chk("reset_busy", busy, 1'b0);
            chk("reset_done", done, 1'b0);
        end

        // Layer with valid always high: exact minimum length
        run_layer(11'd100, 11'd500, 11'd0, 1'b0, -10, 1400, dk);
        chk("layer_length", dk, KIJ * KIJ_LEN);

        repeat (3) tick();
        // Drain stalls and PSUM address wrap (kij=1 begins at 28)
        run_layer(11'd2000, 11'd1030, 11'd2040, 1'b1, -10, 4000, dk);

        repeat (3) tick();
        // Reset during EXE of kij=3 (EXE spans 496..531)
        run_layer(11'd0, 11'd0, 11'd100, 1'b0, 3 * KIJ_LEN + EXE_K + 4, 1400, dk);
        chk("abort_taken", dk, -2);
        repeat (3) tick();
        chk("post_abort_idle", inst, IDLE_W);

        // Restart from kij=0
        run_layer(11'd40, 11'd600, 11'd300, 1'b0, -10, 1400, dk);
        chk("restart_length", dk, KIJ * KIJ_LEN);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
